// File: rtl/pkt_tx_pkg.sv
// pkt_tx shared types: packet layout, FSM states, LFSR seed.
// Optional build macro: PKT_TX_LFSR_EN (random packet content).
package pkt_tx_pkg;

   localparam int PKT_W   = 16;
   localparam int SRC_LSB = 0;
   localparam int TGT_LSB = 4;
   localparam int DAT_LSB = 8;

   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } tx_state_t;

   typedef logic [PKT_W-1:0] pkt_t;

   function automatic logic [3:0] src_onehot(input int unsigned id);
      logic [1:0] idx;
      idx = id[1:0];
      return 4'b0001 << idx;
   endfunction

   function automatic pkt_t pkt_pack(
      input logic [3:0] src,
      input logic [3:0] tgt,
      input logic [7:0] dat
   );
      pkt_t p;
      p = '0;
      p[SRC_LSB +: 4] = src;
      p[TGT_LSB +: 4] = tgt;
      p[DAT_LSB +: 8] = dat;
      return p;
   endfunction

   // Fibonacci taps 16,14,13,11 (1-based)
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction

endpackage

// File: rtl/pkt_tx_if.sv
// pkt_tx command and switch-side bus.
// master drives commands / backpressure, slave is the transmitter.
interface pkt_tx_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic [3:0] cmd_target;
   logic [7:0] cmd_data;
   logic [3:0] cmd_len;
   logic [3:0] cmd_gap;
   logic       cmd_rand;
   logic       full_in;
   logic       valid_out;
   logic [3:0] source_out;
   logic [3:0] target_out;
   logic [7:0] data_out;

   modport master (
      output cmd_valid,
      output cmd_target,
      output cmd_data,
      output cmd_len,
      output cmd_gap,
      output cmd_rand,
      output full_in,
      input  cmd_ready,
      input  valid_out,
      input  source_out,
      input  target_out,
      input  data_out
   );

   modport slave (
      input  cmd_valid,
      input  cmd_target,
      input  cmd_data,
      input  cmd_len,
      input  cmd_gap,
      input  cmd_rand,
      input  full_in,
      output cmd_ready,
      output valid_out,
      output source_out,
      output target_out,
      output data_out
   );

endinterface

// File: rtl/pkt_tx_lfsr.sv
// Free-running 16-bit Fibonacci LFSR for random packet content.
// Only instantiated when PKT_TX_LFSR_EN is defined.
module pkt_tx_lfsr
   import pkt_tx_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   output logic [15:0] lfsr_q
);

   // advance once per cycle, reseed on reset
   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr_q <= LFSR_SEED;
      end else begin
         lfsr_q <= lfsr_step(lfsr_q);
      end
   end

endmodule

// File: rtl/pkt_tx.sv
// pkt_tx: burst packet transmitter feeding one switch input port.
// Build option PKT_TX_LFSR_EN adds LFSR-driven random target/data.
module pkt_tx
   import pkt_tx_pkg::*;
#(
   parameter int unsigned PORT_ID = 0
) (
   input  logic        clk,
   input  logic        rst,
   pkt_tx_if.slave     tx,
   output logic        busy,
   output logic [15:0] sent_cnt,
   output logic [15:0] stall_cnt,
   output logic [7:0]  rej_cnt
);

   localparam logic [3:0] SRC = src_onehot(PORT_ID);

   tx_state_t  state_q;
   tx_state_t  state_d;
   pkt_t       pkt_q;
   pkt_t       pkt_d;
   logic [3:0] rem_q;
   logic [3:0] gap_q;
   logic [3:0] gcnt_q;
   logic       fin_q;

   logic       accept;
   logic       start;
   logic       reject;
   logic       send;
   logic       stall;
   logic       more;
   logic       gap_end;
   logic       reload;

   // rem_q counts packets still to come after the pending one;
   // fin_q marks that the final packet already left (used in GAP)
   assign accept  = tx.cmd_valid & tx.cmd_ready;
   assign start   = accept & (|tx.cmd_target);
   assign reject  = accept & ~(|tx.cmd_target);
   assign send    = (state_q == ST_SEND) & ~tx.full_in;
   assign stall   = (state_q == ST_SEND) & tx.full_in;
   assign more    = (rem_q != 4'd0);
   assign gap_end = (state_q == ST_GAP) & (gcnt_q == 4'd1);
   assign reload  = (send & (gap_q == 4'd0) & more)
                  | (gap_end & ~fin_q);

   assign tx.cmd_ready = (state_q == ST_IDLE);
   assign busy         = (state_q != ST_IDLE);

   // fields are registered; valid is gated by full_in in the same
   // cycle so a packet is never shown to a full switch FIFO
   assign tx.valid_out  = send;
   assign tx.source_out = pkt_q[SRC_LSB +: 4];
   assign tx.target_out = pkt_q[TGT_LSB +: 4];
   assign tx.data_out   = pkt_q[DAT_LSB +: 8];

`ifdef PKT_TX_LFSR_EN
   logic [15:0] lfsr_q;
   logic        rand_q;
   logic [3:0]  rnd_tgt;
   logic [7:0]  rnd_dat;
   logic        unused_lfsr;

   pkt_tx_lfsr u_lfsr (
      .clk    (clk),
      .rst    (rst),
      .lfsr_q (lfsr_q)
   );

   assign rnd_tgt = (lfsr_q[3:0] == 4'h0) ? 4'hF : lfsr_q[3:0];
   assign rnd_dat = lfsr_q[11:4];
   assign unused_lfsr = ^lfsr_q[15:12];

   // remember whether the running burst wants random content
   always_ff @(posedge clk) begin
      if (rst) begin
         rand_q <= 1'b0;
      end else if (start) begin
         rand_q <= tx.cmd_rand;
      end
   end
`else
   logic unused_rand;
   assign unused_rand = tx.cmd_rand;
`endif

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_SEND;
            end
         end
         ST_SEND: begin
            if (send) begin
               if (gap_q != 4'd0) begin
                  state_d = ST_GAP;
               end else if (!more) begin
                  state_d = ST_IDLE;
               end
            end
         end
         ST_GAP: begin
            if (gap_end) begin
               state_d = fin_q ? ST_IDLE : ST_SEND;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // next packet fields: load on accept, step data after each send
   always_comb begin
      pkt_d = pkt_q;
      if (start) begin
         pkt_d = pkt_pack(SRC, tx.cmd_target, tx.cmd_data);
      end else if (send) begin
         pkt_d[DAT_LSB +: 8] = pkt_q[DAT_LSB +: 8] + 8'd1;
      end
`ifdef PKT_TX_LFSR_EN
      if ((start & tx.cmd_rand) | (reload & rand_q)) begin
         pkt_d = pkt_pack(SRC, rnd_tgt, rnd_dat);
      end
`else
      if (reload) begin
         pkt_d[SRC_LSB +: 4] = SRC;
      end
`endif
   end

   // burst bookkeeping: packet fields, remaining count, gap timer
   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_q  <= pkt_pack(SRC, 4'h0, 8'h00);
         rem_q  <= 4'd0;
         gap_q  <= 4'd0;
         gcnt_q <= 4'd0;
         fin_q  <= 1'b0;
      end else begin
         pkt_q <= pkt_d;
         if (start) begin
            rem_q <= tx.cmd_len;
            gap_q <= tx.cmd_gap;
            fin_q <= 1'b0;
         end else if (send) begin
            if (more) begin
               rem_q <= rem_q - 4'd1;
            end
            fin_q <= ~more;
         end
         if (send) begin
            gcnt_q <= gap_q;
         end else if (state_q == ST_GAP) begin
            gcnt_q <= gcnt_q - 4'd1;
         end
      end
   end

   // saturating statistics counters
   always_ff @(posedge clk) begin
      if (rst) begin
         sent_cnt  <= '0;
         stall_cnt <= '0;
         rej_cnt   <= '0;
      end else begin
         if (send && sent_cnt != 16'hFFFF) begin
            sent_cnt <= sent_cnt + 16'd1;
         end
         if (stall && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
         end
         if (reject && rej_cnt != 8'hFF) begin
            rej_cnt <= rej_cnt + 8'd1;
         end
      end
   end

endmodule
